// File: rtl/csa_pkg.sv
// Shared types and constants for the multi-precision conditional-sum sequencer.
package csa_pkg;

  localparam int CSA_SLICE_W = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int csa_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/csa_word_sequencer_if.sv
// Operand/result valid-ready bus between a requester and the word sequencer.
interface csa_word_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 8 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/conditional_sum_adder.sv
// 8-bit conditional-sum adder: each group precomputes results for carry-in 0 and 1,
// then groups are merged pairwise (1 -> 2 -> 4 -> 8 bits) with the lower group's carry.
module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] s0_l0, s1_l0, c0_l0, c1_l0;
  logic [7:0] s0_l1, s1_l1;
  logic [3:0] c0_l1, c1_l1;
  logic [7:0] s0_l2, s1_l2;
  logic [1:0] c0_l2, c1_l2;
  logic [7:0] s0_l3, s1_l3;
  logic       c0_l3, c1_l3;

  // Single-bit groups: suffix 0 assumes carry-in 0, suffix 1 assumes carry-in 1.
  assign s0_l0 = x ^ y;
  assign s1_l0 = ~(x ^ y);
  assign c0_l0 = x & y;
  assign c1_l0 = x | y;

  for (genvar j = 0; j < 4; j++) begin : g_l1
    assign s0_l1[2*j]   = s0_l0[2*j];
    assign s1_l1[2*j]   = s1_l0[2*j];
    assign s0_l1[2*j+1] = c0_l0[2*j] ? s1_l0[2*j+1] : s0_l0[2*j+1];
    assign s1_l1[2*j+1] = c1_l0[2*j] ? s1_l0[2*j+1] : s0_l0[2*j+1];
    assign c0_l1[j]     = c0_l0[2*j] ? c1_l0[2*j+1] : c0_l0[2*j+1];
    assign c1_l1[j]     = c1_l0[2*j] ? c1_l0[2*j+1] : c0_l0[2*j+1];
  end

  for (genvar j = 0; j < 2; j++) begin : g_l2
    assign s0_l2[4*j +: 2]   = s0_l1[4*j +: 2];
    assign s1_l2[4*j +: 2]   = s1_l1[4*j +: 2];
    assign s0_l2[4*j+2 +: 2] = c0_l1[2*j] ? s1_l1[4*j+2 +: 2] : s0_l1[4*j+2 +: 2];
    assign s1_l2[4*j+2 +: 2] = c1_l1[2*j] ? s1_l1[4*j+2 +: 2] : s0_l1[4*j+2 +: 2];
    assign c0_l2[j]          = c0_l1[2*j] ? c1_l1[2*j+1] : c0_l1[2*j+1];
    assign c1_l2[j]          = c1_l1[2*j] ? c1_l1[2*j+1] : c0_l1[2*j+1];
  end

  assign s0_l3 = {(c0_l2[0] ? s1_l2[7:4] : s0_l2[7:4]), s0_l2[3:0]};
  assign s1_l3 = {(c1_l2[0] ? s1_l2[7:4] : s0_l2[7:4]), s1_l2[3:0]};
  assign c0_l3 = c0_l2[0] ? c1_l2[1] : c0_l2[1];
  assign c1_l3 = c1_l2[0] ? c1_l2[1] : c0_l2[1];

  assign sum  = cin ? s1_l3 : s0_l3;
  assign cout = cin ? c1_l3 : c0_l3;

endmodule

// File: rtl/csa_word_sequencer.sv
// Multi-precision add/subtract: one 8-bit conditional-sum adder reused across WORDS
// byte slices, LSB first, with the carry chained through a register.
module csa_word_sequencer
  import csa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  csa_word_sequencer_if.slave bus
);

  localparam int W     = CSA_SLICE_W * WORDS;
  localparam int CNT_W = csa_clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORDS - 1);

  seq_state_e       state, state_next;
  logic [CNT_W-1:0] k;
  logic [W-1:0]     a_r, b_r, sum_r;
  logic             carry_r, cout_r, ovf_r;
  logic             accept, step, last;
  logic [CSA_SLICE_W-1:0] x, y, slice_sum;
  logic             slice_cout;

  assign last = (k == LAST_K);

  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst) begin
          accept     = 1'b1;
          state_next = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        step = 1'b1;
        if (last) state_next = SEQ_DONE;
      end
      SEQ_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  assign x = a_r[k*CSA_SLICE_W +: CSA_SLICE_W];
  assign y = b_r[k*CSA_SLICE_W +: CSA_SLICE_W];

  conditional_sum_adder u_adder (
    .x    (x),
    .y    (y),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Subtraction is folded into the operand latch: B is inverted and the +1 enters as carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= bus.a;
      b_r     <= bus.sub ? ~bus.b : bus.b;
      carry_r <= bus.sub;
      sum_r   <= '0;
      k       <= '0;
    end else if (step) begin
      sum_r[k*CSA_SLICE_W +: CSA_SLICE_W] <= slice_sum;
      carry_r <= slice_cout;
      k       <= k + 1'b1;
      if (last) begin
        cout_r <= slice_cout;
        ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_sum[CSA_SLICE_W-1] != a_r[W-1]);
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: doc/csa_word_sequencer.md
Name: csa_word_sequencer

Overview:
- Multi-precision add/subtract controller that time-multiplexes one 8-bit `conditional_sum_adder` across WORDS byte slices, LSB first.
- Chains the carry through a register and produces a full 8*WORDS-bit result.
- Valid/ready handshake on both the operand side and the result side.
- Sits between a requester (accumulator or ALU front end) and the existing 8-bit conditional-sum datapath; the datapath itself is not modified.

Parameters:
- WORDS, 4, number of 8-bit slices per operand; operand width W = 8*WORDS; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  sequencer can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A-B; sampled with a and b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1; out_valid=0, sum=0, cout=0, ovf=0. Internal slice counter = 0, carry register = 0.
- States and transitions:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after slice WORDS-1 completes.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE) and not in reset. Inputs are ignored whenever in_ready=0.
- Accept edge:
  - Latch A_r=a and B_r = sub ? ~b : b.
  - carry_r = sub. Subtraction is A + ~B + 1.
  - Slice index k=0. Clear the sum register.
- RUN, one slice per cycle:
  - Adder inputs: x=A_r[8k+7:8k], y=B_r[8k+7:8k], cin=carry_r. The path is purely combinational inside the cycle.
  - On the edge: sum_r[8k+7:8k] <= adder sum; carry_r <= adder cout; k <= k+1.
  - At k==WORDS-1: cout <= adder cout; ovf <= (A_r[W-1]==B_r[W-1]) && (adder sum[7] != A_r[W-1]). B_r is the possibly inverted operand.
- Latency: with the accept edge at E0, out_valid rises after edge E0+WORDS. This is exactly WORDS cycles; no extra output stage.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable until out_ready is seen high.
  - Leaving DONE drops out_valid on the next edge and re-asserts in_ready. A new accept is therefore possible at the earliest one cycle after the result handshake; there is no same-cycle turnaround.
  - sum, cout and ovf keep their last values after out_valid drops; they are valid only while out_valid=1.
- Reset mid-operation (RUN or DONE): synchronous abort. The next state is IDLE with all outputs at reset values and the partial result discarded.
- out_ready high outside DONE: no effect.
- Counter width: clog2(WORDS). No wrap beyond WORDS-1, because the state leaves RUN first.
- Signed/unsigned: sum is modulo 2^W. cout is the unsigned carry and ovf is the signed overflow; both are always reported, and the consumer chooses which to use.

Decomposition:
- Shared package `csa_pkg`: state enum (`SEQ_IDLE`, `SEQ_RUN`, `SEQ_DONE`), the constant `CSA_SLICE_W = 8`, and a clog2 helper function.
- One sub-module, the existing `conditional_sum_adder`, instantiated once and driven combinationally from the slice mux.
- Slice select and sum write-back stay inline; no other sub-modules.

Test Plan:
- Add full ripple (WORDS=4): a=0x0000_0001, b=0xFFFF_FFFF, sub=0 → sum=0x0000_0000, cout=1, ovf=0; out_valid rises exactly 4 edges after accept.
- Subtract with borrow: a=5, b=7, sub=1 → sum=0xFFFF_FFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 → sum=2, cout=1.
- Signed overflow:
  - a=0x7FFF_FFFF, b=1, add → sum=0x8000_0000, ovf=1, cout=0.
  - a=0x8000_0000, b=1, sub → sum=0x7FFF_FFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_valid, sum, cout and ovf are unchanged each cycle and in_ready=0. in_valid pulses during RUN/DONE are ignored. Release out_ready → in_ready=1 on the following cycle.
- Reset mid-RUN: assert rst at slice k=2 → the next cycle shows IDLE, out_valid=0, sum=0. A fresh transaction 0x1234_5678+0x1111_1111 then yields 0x2345_6789.
- Random regression: 10k random a, b and sub, with randomised out_ready stalls → sum/cout match {cout,sum} = a ± b from a W+1-bit golden model, and ovf matches the signed model.
